// File: rtl/loader_pkg.sv
// Shared types and widths for the UART program loader.
// UART_PARITY_EN adds an even-parity bit and the PARITY receiver state.
package loader_pkg;

  localparam int DATA_BITS = 8;
  localparam int WORD_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

  typedef enum logic {
    PH_HI,
    PH_LO
  } phase_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchronizer, bit timer and frame FSM.
// UART_PARITY_EN inserts an even-parity check before the stop bit.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 load_en,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_valid,
  output logic                 byte_err,
  output logic                 busy
);

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LAST = 3'(DATA_BITS - 1);

  rx_state_t   state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_q;
  logic        tick;

  always_comb begin
    tick = (state == START) ? (cnt == HALF)
                            : (cnt == FULL);
  end

  // Accept/reject pulses fire on the sampling cycle itself
  always_comb begin
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    if (load_en && tick) begin
      unique case (state)
        STOP: begin
          byte_valid = rx_s2;
          byte_err   = !rx_s2;
        end
`ifdef UART_PARITY_EN
        PARITY: byte_err = (^byte_data) ^ rx_s2;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_q      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_data <= '0;
      busy      <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
      if (!load_en) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!rx_s2 && rx_q) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (tick) begin
              cnt     <= '0;
              bit_idx <= '0;
              if (rx_s2) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          DATA: begin
            if (tick) begin
              cnt       <= '0;
              byte_data <= {rx_s2, byte_data[DATA_BITS-1:1]};
              bit_idx   <= bit_idx + 3'd1;
              if (bit_idx == LAST) begin
`ifdef UART_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
`ifdef UART_PARITY_EN
          PARITY: begin
            if (tick) begin
              cnt <= '0;
              if (byte_err) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= STOP;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
`endif
          STOP: begin
            if (tick) begin
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Assembles UART bytes into 16-bit program words for the programmer.
// UART_PARITY_EN enables even parity in the byte receiver.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ROM_DEPTH    = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              load_en,
  output logic [WORD_W-1:0] programOut,
  output logic              LMout,
  output logic [14:0]       word_count,
  output logic              busy,
  output logic              frame_err,
  output logic              overflow
);

  localparam logic [14:0] DEPTH = 15'(ROM_DEPTH);

  logic [DATA_BITS-1:0] byte_data;
  logic [DATA_BITS-1:0] hi_byte;
  logic                 byte_valid;
  logic                 byte_err;
  logic                 load_en_q;
  phase_t               phase;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .load_en   (load_en),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .busy      (busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      programOut <= '0;
      LMout      <= 1'b0;
      word_count <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      hi_byte    <= '0;
      load_en_q  <= 1'b0;
      phase      <= PH_HI;
    end else begin
      LMout     <= 1'b0;
      load_en_q <= load_en;
      if (load_en && !load_en_q) begin
        word_count <= '0;
        frame_err  <= 1'b0;
        overflow   <= 1'b0;
        phase      <= PH_HI;
      end else if (!load_en) begin
        phase <= PH_HI;
      end else if (byte_err) begin
        frame_err <= 1'b1;
        phase     <= PH_HI;
      end else if (byte_valid) begin
        if (phase == PH_HI) begin
          hi_byte <= byte_data;
          phase   <= PH_LO;
        end else begin
          phase <= PH_HI;
          // Words beyond the ROM are flagged, never emitted
          if (word_count == DEPTH) begin
            overflow <= 1'b1;
          end else begin
            programOut <= {hi_byte, byte_data};
            LMout      <= 1'b1;
            word_count <= word_count + 15'd1;
          end
        end
      end
    end
  end

endmodule
